// File: rtl/pc_pkg.sv
// Shared PCDrive encodings and PC types.
// Used by the next-address logic and the PC register.
package pc_pkg;

  localparam int PC_W = 32;

  typedef logic [PC_W-1:0] pc_t;

  typedef enum logic [2:0] {
    PC_HOLD = 3'b000,
    PC_INC  = 3'b001,
    PC_DEC  = 3'b010,
    PC_LOAD = 3'b011,
    PC_REL  = 3'b100
  } pc_op_e;

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC mux and fetch-strobe decode.
// Encodings outside the named set fall back to hold.
module pc_next
  import pc_pkg::*;
#(
  parameter pc_t INC_STEP = 32'd4
) (
  input  pc_t        addr,
  input  pc_t        set,
  input  logic [2:0] drive,
  output pc_t        next,
  output logic       fire
);

  logic is_inc;
  logic is_dec;
  logic is_load;
  logic is_rel;

  assign is_inc  = (drive == PC_INC);
  assign is_dec  = (drive == PC_DEC);
  assign is_load = (drive == PC_LOAD);
  assign is_rel  = (drive == PC_REL);

  // Signed offset add is the same bit pattern as unsigned mod 2^32.
  always_comb begin
    next = addr;
    fire = 1'b0;
    unique case (1'b1)
      is_inc: begin
        next = addr + INC_STEP;
        fire = 1'b1;
      end
      is_dec: begin
        next = addr - INC_STEP;
        fire = 1'b1;
      end
      is_load: begin
        next = set;
        fire = 1'b1;
      end
      is_rel: begin
        next = addr + set;
        fire = 1'b1;
      end
      default: begin
        next = addr;
        fire = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter register with one-cycle fetch strobe.
// Async active-low reset forces RESET_ADDR and clears the strobe.
module pc_unit
  import pc_pkg::*;
#(
  parameter pc_t RESET_ADDR = 32'h0000_0000,
  parameter pc_t INC_STEP   = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCSet,
  input  logic [2:0]  PCDrive,
  output logic [31:0] PCAddr,
  output logic        GetInstruction
);

  pc_t  next;
  logic fire;

  pc_next #(
    .INC_STEP(INC_STEP)
  ) u_next (
    .addr (PCAddr),
    .set  (PCSet),
    .drive(PCDrive),
    .next (next),
    .fire (fire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PCAddr         <= RESET_ADDR;
      GetInstruction <= 1'b0;
    end else begin
      PCAddr         <= next;
      GetInstruction <= fire;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: stimulus pushes expectations,
// a monitor pops and compares after every rising edge.
module tb_pc_unit;

  localparam logic [31:0] STEP = 32'd4;
  localparam logic [31:0] RADDR = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] PCSet;
  logic [2:0]  PCDrive;
  logic [31:0] PCAddr;
  logic        GetInstruction;

  logic        clk_en;
  logic [32:0] q[$];
  logic [31:0] model_pc;
  int          checks;
  int          errors;

  pc_unit #(
    .RESET_ADDR(RADDR),
    .INC_STEP  (STEP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .PCSet         (PCSet),
    .PCDrive       (PCDrive),
    .PCAddr        (PCAddr),
    .GetInstruction(GetInstruction)
  );

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  // Reference: the operation table written as plain arithmetic.
  function automatic logic [32:0] ref_step(
    input logic [31:0] pc,
    input logic [2:0]  d,
    input logic [31:0] s
  );
    logic [31:0] n;
    logic        g;
    n = pc;
    g = 1'b0;
    case (d)
      3'd1: begin n = pc + STEP; g = 1'b1; end
      3'd2: begin n = pc - STEP; g = 1'b1; end
      3'd3: begin n = s;         g = 1'b1; end
      3'd4: begin n = pc + s;    g = 1'b1; end
      default: begin n = pc; g = 1'b0; end
    endcase
    return {n, g};
  endfunction

  task automatic do_op(input logic [2:0] d, input logic [31:0] s);
    logic [32:0] e;
    @(negedge clk);
    PCDrive = d;
    PCSet   = s;
    e = ref_step(model_pc, d, s);
    model_pc = e[32:1];
    q.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d pending, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic chk_now(
    input string       name,
    input logic [31:0] ea,
    input logic        eg
  );
    checks++;
    if (PCAddr !== ea || GetInstruction !== eg) begin
      errors++;
      $display("FAIL %s: got pc=%h gi=%b, required pc=%h gi=%b",
               name, PCAddr, GetInstruction, ea, eg);
    end
  endtask

  always begin
    logic [32:0] e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (PCAddr !== e[32:1] || GetInstruction !== e[0]) begin
        errors++;
        $display("FAIL monitor: got pc=%h gi=%b, required pc=%h gi=%b",
                 PCAddr, GetInstruction, e[32:1], e[0]);
      end
    end
  end

  initial begin
    logic [2:0]  d;
    logic [31:0] s;
    checks   = 0;
    errors   = 0;
    clk_en   = 1'b0;
    rst      = 1'b1;
    PCDrive  = 3'd0;
    PCSet    = 32'd0;
    model_pc = RADDR;

    #3 rst = 1'b0;
    #1 chk_now("reset_no_clk", 32'h0, 1'b0);
    clk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    do_op(3'b011, 32'd5791);
    drain();
    chk_now("load_5791", 32'd5791, 1'b1);
    do_op(3'b001, 32'd0);
    do_op(3'b001, 32'd0);
    drain();
    chk_now("inc_5799", 32'd5799, 1'b1);

    do_op(3'b100, 32'd33);
    drain();
    chk_now("rel_pos", 32'd5832, 1'b1);
    do_op(3'b100, 32'hFFFF_FFF0);
    drain();
    chk_now("rel_neg", 32'd5816, 1'b1);

    do_op(3'b000, 32'd7894);
    do_op(3'b111, 32'd7894);
    drain();
    chk_now("hold_rsv", 32'd5816, 1'b0);

    do_op(3'b011, 32'd5816);
    drain();
    chk_now("load_same", 32'd5816, 1'b1);

    do_op(3'b011, 32'hFFFF_FFFC);
    do_op(3'b001, 32'd0);
    drain();
    chk_now("wrap_inc", 32'h0000_0000, 1'b1);
    do_op(3'b010, 32'd0);
    drain();
    chk_now("wrap_dec", 32'hFFFF_FFFC, 1'b1);

    do_op(3'b011, 32'd7894);
    drain();
    @(negedge clk);
    PCDrive = 3'b001;
    #2 rst = 1'b0;
    #1 chk_now("async_rst", RADDR, 1'b0);
    @(posedge clk);
    #1 chk_now("rst_override", RADDR, 1'b0);
    model_pc = RADDR;
    @(negedge clk);
    PCDrive = 3'b000;
    rst = 1'b1;
    do_op(3'b001, 32'd0);
    drain();
    chk_now("inc_after_rst", 32'd4, 1'b1);

    for (int i = 0; i < 300; i++) begin
      d = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: s = 32'hFFFF_FFFF - 32'($urandom_range(0, 8));
        1: s = 32'($urandom_range(0, 15));
        default: s = $urandom;
      endcase
      if (i % 37 == 5) begin
        d = 3'b011;
        s = model_pc;
      end
      do_op(d, s);
    end
    @(negedge clk);
    PCDrive = 3'b000;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter RESET_ADDR, default 32'h0000_0000, is the PCAddr value loaded on reset.
REQ-002 Parameter INC_STEP, default 32'd4, is the step used by the INC and DEC operations.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 PCSet  input  32  load value or signed offset operand for PCDrive.
REQ-006 PCDrive  input  3  operation select, sampled on the rising clk edge.
REQ-007 PCAddr  output  32  current program counter, driven directly from a register.
REQ-008 GetInstruction  output  1  registered fetch strobe: 1 for exactly the cycle after PCAddr takes a new value through an operation.

Function
REQ-009 PCDrive=000 HOLD: PCAddr SHALL stay unchanged; GetInstruction SHALL be 0 next cycle.
REQ-010 PCDrive=001 INC: PCAddr SHALL become PCAddr+INC_STEP.
REQ-011 PCDrive=010 DEC: PCAddr SHALL become PCAddr-INC_STEP.
REQ-012 PCDrive=011 LOAD: PCAddr SHALL become PCSet (absolute jump).
REQ-013 PCDrive=100 REL: PCAddr SHALL become PCAddr+PCSet, with PCSet treated as two's-complement signed (relative branch).
REQ-014 PCDrive=101, 110 and 111 are reserved and SHALL behave as HOLD.
REQ-015 All arithmetic SHALL be 32-bit modulo 2^32, wrapping silently with no overflow flag.
REQ-016 No alignment SHALL be enforced; odd or unaligned values are loaded and added as-is.
REQ-017 Latency SHALL be one clock: an operation sampled at edge N is visible on PCAddr after edge N.
REQ-018 GetInstruction SHALL be set to 1 at edge N for any non-HOLD, non-reserved operation sampled at edge N, and to 0 otherwise.
REQ-019 GetInstruction SHALL be 1 even when the new value equals the old one (e.g. LOAD of the current PCAddr).
REQ-020 Back-to-back operations SHALL be accepted every cycle with no stall and no handshake.

Reset
REQ-021 While rst=0, PCAddr SHALL be RESET_ADDR and GetInstruction SHALL be 0, immediately and independent of clk.
REQ-022 Reset asserted mid-operation SHALL override any pending PCDrive.
REQ-023 The first operation SHALL be sampled on the first rising clk edge after rst returns to 1.

Structure
REQ-024 The PCDrive encodings (HOLD, INC, DEC, LOAD, REL) SHALL be named constants in a shared package (pc_pkg), also used by the decoder and control logic.
REQ-025 The next-address selection SHALL be a single combinational mux feeding a 32-bit register plus a 1-bit strobe register.
REQ-026 No sub-module is required; the adder/mux MAY be factored into one combinational sub-module, pc_next.

Verification
REQ-027 Reset: rst=0 pulse with clk idle -> PCAddr=0 and GetInstruction=0 without any clock edge.
REQ-028 LOAD then INC: PCDrive=011 with PCSet=5791 -> PCAddr=5791 and GetInstruction=1; then two edges with PCDrive=001 -> 5795, then 5799.
REQ-029 REL: from PCAddr=5799, PCDrive=100 with PCSet=33 -> 5832; then PCSet=32'hFFFF_FFF0 (-16) -> 5816.
REQ-030 HOLD and reserved: PCDrive=000, then 111, with PCSet=7894 -> PCAddr unchanged and GetInstruction=0 both cycles.
REQ-031 Wrap: LOAD 32'hFFFF_FFFC then INC -> 32'h0000_0000; DEC -> 32'hFFFF_FFFC.
REQ-032 Async reset mid-run: after LOAD 7894, drive rst=0 between clk edges -> PCAddr=0 at once; after release, INC -> 4.
